// File: rtl/ihadamard4_pipe.sv
// ihadamard4_pipe: 3-stage inverse 4-pt Hadamard, rounding divide-by-4, valid/ready with global stall.
// Define IHAD_SAT_EN to clamp out-of-range samples instead of wrapping them.
module ihadamard4_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  y0,
  input  logic signed [IN_W-1:0]  y1,
  input  logic signed [IN_W-1:0]  y2,
  input  logic signed [IN_W-1:0]  y3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] x0,
  output logic signed [OUT_W-1:0] x1,
  output logic signed [OUT_W-1:0] x2,
  output logic signed [OUT_W-1:0] x3,
  output logic                    ovf
);
`ifdef IHAD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int RW = IN_W + 3;
  localparam logic signed [RW-1:0] MAXV = RW'(2**(OUT_W-1)-1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2**(OUT_W-1)));
  logic advance, v1, v2;
  logic signed [IN_W:0] ye [4];
  logic signed [IN_W:0] a [4];
  logic signed [IN_W+1:0] ae [4];
  logic signed [IN_W+1:0] s [4];
  logic signed [RW-1:0] r [4];
  logic signed [OUT_W-1:0] xn [4];
  logic signed [OUT_W-1:0] xr [4];
  logic [3:0] oor;
  assign advance  = start & ~(out_valid & ~out_ready);
  assign in_ready = advance;
  assign ye[0] = {y0[IN_W-1], y0};
  assign ye[1] = {y1[IN_W-1], y1};
  assign ye[2] = {y2[IN_W-1], y2};
  assign ye[3] = {y3[IN_W-1], y3};
  assign x0 = xr[0];
  assign x1 = xr[1];
  assign x2 = xr[2];
  assign x3 = xr[3];
  genvar i;
  for (i = 0; i < 4; i++) begin : g_lane
    assign ae[i]  = {a[i][IN_W], a[i]};
    // +2 then arithmetic >>2 rounds halves toward +inf
    assign r[i]   = ($signed({{2{s[i][IN_W+1]}}, s[i]}) + RW'(2)) >>> 2;
    assign oor[i] = (r[i] > MAXV) | (r[i] < MINV);
    assign xn[i]  = (SAT && r[i] > MAXV) ? MAXV[OUT_W-1:0] :
                    (SAT && r[i] < MINV) ? MINV[OUT_W-1:0] : r[i][OUT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a[k]  <= '0;
        s[k]  <= '0;
        xr[k] <= '0;
      end
    end else if (advance) begin
      v1        <= in_valid;
      a[0]      <= ye[0] + ye[1];
      a[1]      <= ye[0] - ye[1];
      a[2]      <= ye[2] + ye[3];
      a[3]      <= ye[2] - ye[3];
      v2        <= v1;
      s[0]      <= ae[0] + ae[2];
      s[1]      <= ae[1] + ae[3];
      s[2]      <= ae[0] - ae[2];
      s[3]      <= ae[1] - ae[3];
      out_valid <= v2;
      ovf       <= ovf | (v2 & |oor);
      for (int k = 0; k < 4; k++) xr[k] <= xn[k];
    end
  end
endmodule

// File: tb/tb_ihadamard4_pipe.sv
// tb_ihadamard4_pipe: table vectors plus streaming/stall/freeze/reset sequences, scoreboard-checked.
module tb_ihadamard4_pipe;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic signed [10:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;
  logic signed [8:0] x0, x1, x2, x3;
  typedef struct { int y[4]; int x[4]; bit ov; } row_t;
  row_t tbl[7];
  logic [35:0] sb[$];
  int passed = 0, total = 0, npop = 0;

  ihadamard4_pipe dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [35:0] pack(input int a, input int b, input int c, input int d);
    return {a[8:0], b[8:0], c[8:0], d[8:0]};
  endfunction

  function automatic logic [35:0] model(input int a, input int b, input int c, input int d);
    int s[4];
    int r;
    logic [35:0] v;
    s = '{a+b+c+d, a-b+c-d, a+b-c-d, a-b-c+d};
    v = '0;
    for (int k = 0; k < 4; k++) begin
      r = (s[k] + 2) >>> 2;
`ifdef IHAD_SAT_EN
      if (r > 255) r = 255;
      else if (r < -256) r = -256;
`endif
      v[35-9*k -: 9] = r[8:0];
    end
    return v;
  endfunction

  task automatic row(input int k, input int a, input int b, input int c, input int d,
                     input int e, input int f, input int g, input int h, input bit o);
    tbl[k].y = '{a, b, c, d};
    tbl[k].x = '{e, f, g, h};
    tbl[k].ov = o;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int c, input int d, input logic [35:0] e);
    int n = 0;
    y0 = 11'(a); y1 = 11'(b); y2 = 11'(c); y3 = 11'(d);
    in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("accept", in_ready, 1);
    if (in_ready) sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_rand;
    int q[4];
    for (int k = 0; k < 4; k++) q[k] = $urandom_range(0, 2047) - 1024;
    send(q[0], q[1], q[2], q[3], model(q[0], q[1], q[2], q[3]));
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && start && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %0h with empty scoreboard", {x0, x1, x2, x3});
      end else begin
        chk("x_out", {x0, x1, x2, x3}, sb.pop_front());
        npop++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, p0;
    row(0, 10, -2, -4, 0, 1, 2, 3, 4, 1'b0);
    row(1, 2, 0, 0, 0, 1, 1, 1, 1, 1'b0);
    row(2, 1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    row(3, -2, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    row(4, -10, 2, 4, 0, -1, -2, -3, -4, 1'b0);
    row(5, 6, 0, 0, 0, 2, 2, 2, 2, 1'b0);
`ifdef IHAD_SAT_EN
    row(6, 1023, 1023, 1023, 1023, 255, 0, 0, 0, 1'b1);
`else
    row(6, 1023, 1023, 1023, 1023, -1, 0, 0, 0, 1'b1);
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_x", {x0, x1, x2, x3}, 0);
    step();
    rst_n = 1'b1;
    step();
    // latency: capturing edge counts as 1
    send(10, -2, -4, 0, pack(1, 2, 3, 4));
    cnt = 1;
    while (!out_valid && cnt < 10) begin step(); cnt++; end
    chk("latency_edges", cnt, 3);
    drain();
    chk("ovf_after_first", ovf, 0);
    for (int k = 0; k < 7; k++) begin
      send(tbl[k].y[0], tbl[k].y[1], tbl[k].y[2], tbl[k].y[3],
           pack(tbl[k].x[0], tbl[k].x[1], tbl[k].x[2], tbl[k].x[3]));
      drain();
      chk($sformatf("ovf_row%0d", k), ovf, tbl[k].ov);
    end
    // stream of 8 with a 3-cycle downstream stall
    p0 = npop;
    fork
      begin : g_stream
        for (int k = 0; k < 8; k++) send_rand();
      end
      begin : g_stall
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", in_ready, 1);
      end
    join
    drain();
    chk("stream_count", npop - p0, 8);
    // freeze with two vectors in flight
    p0 = npop;
    send_rand();
    send_rand();
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("freeze_out_valid", out_valid, 0);
      chk("freeze_in_ready", in_ready, 0);
      step();
    end
    start = 1'b1;
    drain();
    chk("freeze_count", npop - p0, 2);
    // async reset with vectors in flight
    chk("ovf_before_rst", ovf, 1);
    for (int k = 0; k < 5; k++) send_rand();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_x", {x0, x1, x2, x3}, 0);
    chk("arst_ovf", ovf, 0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    step();
    send(10, -2, -4, 0, pack(1, 2, 3, 4));
    drain();
    chk("post_rst_ovf", ovf, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
